spmv_lane: RTL and testbench

Consumes one channel of the fetcher's three-field FIFO output (value, column, row) and performs the sparse matrix–vector multiply–accumulate for that channel. Each triple is multiplied by the dense vector element `x[col]` from a local vector RAM and accumulated per row. A finished row sum is emitted on a valid/ready port when the row index changes or on flush. One instance sits downstream of each fetcher channel.

---
 rtl/spmv_lane_pkg.sv | 21 ++
 rtl/spmv_lane_if.sv | 38 +++
 rtl/spmv_lane_vector_ram.sv | 27 ++
 rtl/spmv_lane.sv | 170 +++++++++++++++++
 tb/tb_spmv_lane.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spmv_lane_pkg.sv
// Shared definitions for the sparse matrix-vector multiply lane:
// field geometry, field slot indices inside the FIFO word, and lane states.
package spmv_lane_pkg;

  localparam int FIELD_W = 8;
  localparam int ACC_W   = 24;

  // Slot index of each field inside the concatenated FIFO word / flag vector.
  localparam int FLD_VAL = 0;
  localparam int FLD_COL = 1;
  localparam int FLD_ROW = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LOOKUP = 3'd2,
    ST_MAC    = 3'd3,
    ST_EMIT   = 3'd4
  } lane_state_e;

endpackage

// File: rtl/spmv_lane_if.sv
// Bundle between one fetcher channel / vector loader / result sink and a lane.
//
// Result handshake: y_valid/y_ready follow strict valid/ready rules. A result
// transfers on every rising clk edge where y_valid && y_ready. Once y_valid is
// raised, y_valid, y_row and y_sum stay stable until that transfer; y_valid
// never depends combinationally on y_ready.
interface spmv_lane_if #(
  parameter int FIELD_W = spmv_lane_pkg::FIELD_W,
  parameter int ACC_W   = spmv_lane_pkg::ACC_W
);
  // Fetcher FIFO side (standard, non-FWFT: fields valid the cycle after read)
  logic [2:0]           empty;
  logic [3*FIELD_W-1:0] fields;
  logic [2:0]           read;
  // Dense vector loader
  logic                 x_we;
  logic [FIELD_W-1:0]   x_addr;
  logic [FIELD_W-1:0]   x_data;
  // Control and result port
  logic                 flush;
  logic                 y_valid;
  logic                 y_ready;
  logic [FIELD_W-1:0]   y_row;
  logic [ACC_W-1:0]     y_sum;
  logic                 busy;

  // Environment side: drives FIFO data, vector writes, flush and y_ready.
  modport master (
    output empty, fields, x_we, x_addr, x_data, flush, y_ready,
    input  read, y_valid, y_row, y_sum, busy
  );

  // Lane side.
  modport slave (
    input  empty, fields, x_we, x_addr, x_data, flush, y_ready,
    output read, y_valid, y_row, y_sum, busy
  );
endinterface

// File: rtl/spmv_lane_vector_ram.sv
// Dense vector storage: one synchronous write port, one synchronous read port
// with 1-cycle latency. A same-address read/write returns the old contents.
// Contents survive reset on purpose: the vector is loaded once per matrix.
module vector_ram #(
  parameter int DEPTH = 256,
  parameter int W     = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  // Write and read in the same block so a colliding read sees pre-write data.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/spmv_lane.sv
// One SpMV lane: pops (value, col, row) triples from a fetcher channel,
// multiplies value by x[col] and accumulates per row. A row sum is emitted
// when the row index changes, or on flush while idle with nothing to fetch.
module spmv_lane
  import spmv_lane_pkg::*;
#(
  parameter int FIELD_W = spmv_lane_pkg::FIELD_W,
  parameter int ACC_W   = spmv_lane_pkg::ACC_W,
  parameter int X_DEPTH = 2 ** FIELD_W
) (
  input  logic          clk,
  input  logic          rst,
  spmv_lane_if.slave    bus,
  output logic [2:0]    o_state
);

  localparam int PROD_W = 2 * FIELD_W;

  localparam logic [2:0] S_IDLE   = ST_IDLE;
  localparam logic [2:0] S_FETCH  = ST_FETCH;
  localparam logic [2:0] S_LOOKUP = ST_LOOKUP;
  localparam logic [2:0] S_MAC    = ST_MAC;
  localparam logic [2:0] S_EMIT   = ST_EMIT;

  logic [2:0]         r_state;
  logic [2:0]         w_next;

  logic [FIELD_W-1:0] r_val;
  logic [FIELD_W-1:0] r_row;
  logic [FIELD_W-1:0] r_cur_row;
  logic [ACC_W-1:0]   r_acc;
  logic               r_acc_valid;

  logic               r_y_valid;
  logic [FIELD_W-1:0] r_y_row;
  logic [ACC_W-1:0]   r_y_sum;

  logic [FIELD_W-1:0] w_f_val;
  logic [FIELD_W-1:0] w_f_col;
  logic [FIELD_W-1:0] w_f_row;
  logic [FIELD_W-1:0] w_x;
  logic [PROD_W-1:0]  w_prod;
  logic [ACC_W-1:0]   w_prod_ext;
  logic               w_all_avail;
  logic               w_row_same;

  assign w_f_val = bus.fields[FLD_VAL*FIELD_W +: FIELD_W];
  assign w_f_col = bus.fields[FLD_COL*FIELD_W +: FIELD_W];
  assign w_f_row = bus.fields[FLD_ROW*FIELD_W +: FIELD_W];

  // A triple is only complete when all three field FIFOs hold data.
  assign w_all_avail = (bus.empty == 3'b000);
  assign w_row_same  = (r_row == r_cur_row);

  // The RAM is addressed straight from the FIFO word during LOOKUP, so x[col]
  // is on w_x in MAC, aligned with the latched value and row.
  vector_ram #(
    .DEPTH (X_DEPTH),
    .W     (FIELD_W)
  ) u_vector_ram (
    .clk     (clk),
    .i_we    (bus.x_we),
    .i_waddr (bus.x_addr),
    .i_wdata (bus.x_data),
    .i_raddr (w_f_col),
    .o_rdata (w_x)
  );

  assign w_prod     = $signed(r_val) * $signed(w_x);
  assign w_prod_ext = {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};

  // Next-state selection; a complete triple beats flush in IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_all_avail) begin
          w_next = S_FETCH;
        end else if (bus.flush && r_acc_valid) begin
          w_next = S_EMIT;
        end
      end
      S_FETCH:  w_next = S_LOOKUP;
      S_LOOKUP: w_next = S_MAC;
      S_MAC: begin
        if (r_acc_valid && !w_row_same) begin
          w_next = S_EMIT;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_EMIT: begin
        if (r_y_valid && bus.y_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Triple latch, accumulator and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_val       <= '0;
      r_row       <= '0;
      r_cur_row   <= '0;
      r_acc       <= '0;
      r_acc_valid <= 1'b0;
      r_y_valid   <= 1'b0;
      r_y_row     <= '0;
      r_y_sum     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_all_avail && bus.flush && r_acc_valid) begin
            r_y_row     <= r_cur_row;
            r_y_sum     <= r_acc;
            r_y_valid   <= 1'b1;
            r_acc_valid <= 1'b0;
          end
        end
        S_LOOKUP: begin
          r_val <= w_f_val;
          r_row <= w_f_row;
        end
        S_MAC: begin
          if (!r_acc_valid) begin
            r_acc       <= w_prod_ext;
            r_cur_row   <= r_row;
            r_acc_valid <= 1'b1;
          end else if (w_row_same) begin
            r_acc <= r_acc + w_prod_ext;
          end else begin
            // Close the finished row and start the new one in the same cycle.
            r_y_row   <= r_cur_row;
            r_y_sum   <= r_acc;
            r_y_valid <= 1'b1;
            r_acc     <= w_prod_ext;
            r_cur_row <= r_row;
          end
        end
        S_EMIT: begin
          if (r_y_valid && bus.y_ready) begin
            r_y_valid <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // All three field FIFOs pop together, only in FETCH.
  assign bus.read    = {3{r_state == S_FETCH}};
  assign bus.busy    = (r_state != S_IDLE);
  assign bus.y_valid = r_y_valid;
  assign bus.y_row   = r_y_row;
  assign bus.y_sum   = r_y_sum;
  assign o_state     = r_state;

endmodule

// File: tb/tb_spmv_lane.sv
// Bench for spmv_lane: directed sequences, a table of single-product rows,
// and randomized triples checked against a row-grouping reference model.
module tb_spmv_lane;
  import spmv_lane_pkg::*;

  localparam int W = FIELD_W + ACC_W;

  typedef struct {
    logic [7:0]  xv;
    logic [7:0]  av;
    logic [23:0] sum;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  spmv_lane_if #(.FIELD_W(FIELD_W), .ACC_W(ACC_W)) bus ();

  spmv_lane #(.FIELD_W(FIELD_W), .ACC_W(ACC_W), .X_DEPTH(256)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .o_state (dbg_state)
  );

  // ---------------- scoreboard / model state ----------------
  logic [W-1:0]  exp_q[$];
  logic [23:0]   fifo_q[$];
  logic [7:0]    xm[256];
  bit            use_model = 1'b0;
  bit            ptl_mode  = 1'b0;
  bit            rnd_ready = 1'b0;
  logic [7:0]    m_row;
  logic [23:0]   m_acc;
  bit            m_valid = 1'b0;
  int            checks = 0;
  int            failures = 0;
  vec_t          tbl[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One clock: model the non-FWFT FIFO pop and check any completed result.
  task automatic tick();
    logic [2:0]   rd_pre;
    bit           hs;
    logic [W-1:0] y_pre;
    rd_pre = bus.read;
    hs     = bus.y_valid && bus.y_ready;
    y_pre  = {bus.y_row, bus.y_sum};
    @(posedge clk);
    #1;
    if (rd_pre == 3'b111) begin
      if (fifo_q.size() > 0) begin
        bus.fields = fifo_q.pop_front();
      end else begin
        checks++;
        failures++;
        $display("FAIL read_while_empty actual=read expected=no_read");
      end
    end
    if (!ptl_mode) bus.empty = (fifo_q.size() == 0) ? 3'b111 : 3'b000;
    if (hs) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result actual=%0h expected=none", y_pre);
      end else begin
        check("y_result", 64'(y_pre), 64'(exp_q.pop_front()));
      end
    end
    if (rnd_ready) bus.y_ready = 1'($urandom_range(0, 1));
  endtask

  // ---------------- driver tasks ----------------
  task automatic write_x(input logic [7:0] a, input logic [7:0] d);
    bus.x_we   = 1'b1;
    bus.x_addr = a;
    bus.x_data = d;
    tick();
    bus.x_we = 1'b0;
    xm[a] = d;
  endtask

  // Reference model: a row's sum is the wrapped sum of its products; a
  // result is due whenever a triple names a different row than the last.
  task automatic push_triple(input logic [7:0] row, input logic [7:0] col, input logic [7:0] val);
    int p;
    fifo_q.push_back({row, col, val});
    if (!ptl_mode) bus.empty = 3'b000;
    if (use_model) begin
      p = $signed(val) * $signed(xm[col]);
      if (m_valid && row == m_row) begin
        m_acc = m_acc + 24'(p);
      end else begin
        if (m_valid) exp_q.push_back({m_row, m_acc});
        m_row   = row;
        m_acc   = 24'(p);
        m_valid = 1'b1;
      end
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    bit done;
    n = 0;
    done = (fifo_q.size() == 0) && !bus.busy;
    while (!done && n < budget) begin
      tick();
      n++;
      done = (fifo_q.size() == 0) && !bus.busy;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=busy expected=idle", name);
    end
  endtask

  task automatic wait_y_valid(input string name, input int budget);
    int n;
    n = 0;
    while (!bus.y_valid && n < budget) begin
      tick();
      n++;
    end
    check(name, 64'(bus.y_valid), 64'(1'b1));
  endtask

  task automatic flush_raw();
    wait_idle("pre_flush", 200);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    wait_idle("post_flush", 200);
  endtask

  task automatic do_flush();
    if (use_model && m_valid) begin
      exp_q.push_back({m_row, m_acc});
      m_valid = 1'b0;
    end
    flush_raw();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [7:0] row;
    bus.empty   = 3'b111;
    bus.fields  = '0;
    bus.x_we    = 1'b0;
    bus.x_addr  = '0;
    bus.x_data  = '0;
    bus.flush   = 1'b0;
    bus.y_ready = 1'b1;

    tbl[0] = '{xv: 8'd5,   av: 8'd4,   sum: 24'd20};
    tbl[1] = '{xv: 8'hFE,  av: 8'd3,   sum: 24'hFFFFFA};
    tbl[2] = '{xv: 8'h80,  av: 8'h80,  sum: 24'h004000};
    tbl[3] = '{xv: 8'd127, av: 8'h80,  sum: 24'hFFC080};
    tbl[4] = '{xv: 8'd127, av: 8'd127, sum: 24'h003F01};
    tbl[5] = '{xv: 8'd0,   av: 8'hFB,  sum: 24'd0};
    tbl[6] = '{xv: 8'hFF,  av: 8'hFF,  sum: 24'd1};

    // Reset values
    tick();
    tick();
    check("rst_outputs", {bus.read, bus.y_valid, bus.busy, bus.y_row, bus.y_sum},
          {3'b000, 1'b0, 1'b0, 8'd0, 24'd0});
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    rst = 1'b0;
    tick();

    // Single row with flush, plus per-cycle timing of the first triple
    write_x(8'd3, 8'd5);
    write_x(8'd7, 8'hFE);
    exp_q.push_back({8'd0, 24'd14});
    push_triple(8'd0, 8'd3, 8'd4);
    tick();
    check("t1_read_high", 64'(bus.read), 64'(3'b111));
    tick();
    check("t2_read_low", 64'(bus.read), 64'(3'b000));
    check("t2_lookup", 64'(dbg_state), 64'(ST_LOOKUP));
    tick();
    check("t3_mac", 64'(dbg_state), 64'(ST_MAC));
    tick();
    check("t4_idle", {dbg_state, bus.busy}, {ST_IDLE, 1'b0});
    push_triple(8'd0, 8'd7, 8'd3);
    wait_idle("single_row", 50);
    flush_raw();

    // Row change emits the previous row; flush emits the last
    write_x(8'd0, 8'd10);
    exp_q.push_back({8'd1, 24'd20});
    push_triple(8'd1, 8'd0, 8'd2);
    push_triple(8'd2, 8'd0, 8'd3);
    wait_idle("row_change", 50);
    check("row_change_emitted", 64'(exp_q.size()), 64'd0);
    exp_q.push_back({8'd2, 24'd30});
    flush_raw();

    // Backpressure in EMIT: result stable, no reads
    bus.y_ready = 1'b0;
    push_triple(8'd3, 8'd0, 8'd1);
    push_triple(8'd4, 8'd0, 8'd1);
    push_triple(8'd4, 8'd0, 8'd2);
    wait_y_valid("bp_valid", 50);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold", {bus.y_valid, bus.read, dbg_state, bus.y_row, bus.y_sum},
            {1'b1, 3'b000, ST_EMIT, 8'd3, 24'd10});
    end
    exp_q.push_back({8'd3, 24'd10});
    bus.y_ready = 1'b1;
    tick();
    check("bp_release", {dbg_state, bus.y_valid}, {ST_IDLE, 1'b0});
    wait_idle("bp_drain", 50);
    exp_q.push_back({8'd4, 24'd30});
    flush_raw();

    // Partial empty never reads; flush with nothing accumulated is silent
    ptl_mode = 1'b1;
    foreach (tbl[k]) begin
      if (k < 4) begin
        bus.empty = (k == 0) ? 3'b100 : (k == 1) ? 3'b001 : (k == 2) ? 3'b011 : 3'b110;
        for (int j = 0; j < 4; j++) begin
          tick();
          check("partial_no_read", {bus.read, bus.busy}, {3'b000, 1'b0});
        end
      end
    end
    ptl_mode  = 1'b0;
    bus.empty = 3'b111;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush_no_acc", {bus.y_valid, bus.busy}, {1'b0, 1'b0});
    tick();
    check("flush_no_acc2", {bus.y_valid, bus.busy}, {1'b0, 1'b0});

    // Accumulator wraps modulo 2^24
    write_x(8'd0, 8'h80);
    for (int i = 0; i < 1024; i++) push_triple(8'd0, 8'd0, 8'h80);
    wait_idle("wrap", 6000);
    exp_q.push_back({8'd0, 24'd0});
    flush_raw();

    // Reset while a result is pending in EMIT
    write_x(8'd0, 8'd10);
    bus.y_ready = 1'b0;
    push_triple(8'd6, 8'd0, 8'd1);
    push_triple(8'd7, 8'd0, 8'd1);
    wait_y_valid("emit_before_rst", 50);
    rst = 1'b1;
    #1;
    check("rst_mid_emit", {bus.y_valid, bus.busy, bus.read, dbg_state},
          {1'b0, 1'b0, 3'b000, ST_IDLE});
    tick();
    rst = 1'b0;
    bus.y_ready = 1'b1;
    tick();
    push_triple(8'd5, 8'd0, 8'd1);
    wait_idle("post_rst", 50);
    exp_q.push_back({8'd5, 24'd10});
    flush_raw();

    // Table of single-product rows
    foreach (tbl[i]) begin
      write_x(8'(32 + i), tbl[i].xv);
      exp_q.push_back({8'(16 + i), tbl[i].sum});
      push_triple(8'(16 + i), 8'(32 + i), tbl[i].av);
      flush_raw();
    end

    // Randomized triples against the reference model, random backpressure
    use_model = 1'b1;
    m_valid   = 1'b0;
    rnd_ready = 1'b1;
    row = 8'($urandom_range(0, 255));
    for (int g = 0; g < 25; g++) begin
      wait_idle("rnd_group", 500);
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
        write_x(8'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
      end
      for (int k = 0; k < int'($urandom_range(1, 6)); k++) begin
        if ($urandom_range(0, 2) == 0) row = 8'($urandom_range(0, 255));
        push_triple(row, 8'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
      end
      if ($urandom_range(0, 1) == 1) do_flush();
    end
    do_flush();
    rnd_ready   = 1'b0;
    bus.y_ready = 1'b1;
    tick();

    check("sb_drained", 64'(exp_q.size()), 64'd0);

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
